// File: rtl/voice_mixer.sv
// voice_mixer: N-voice stereo mixer. On each rising lrck it snapshots one
// signed sample per voice and multiplies each sample by its per-voice gain,
// one voice per clock. The scaled sums are saturated to WIDTH bits.
// Optional feature macro VOICE_MIXER_PAN_EN: when defined, each voice has
// independent left/right gains. When undefined, a single gain and accumulator
// drive both outputs.
module voice_mixer #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned GAIN_BITS = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      lrck_i,
  input  logic [CHANNELS*WIDTH-1:0] samples_i,
  input  logic                      msg_en_i,
  input  logic [31:0]               msg_addr_i,
  input  logic [31:0]               msg_i,
  output logic [WIDTH-1:0]          left_o,
  output logic [WIDTH-1:0]          right_o,
  output logic                      valid_o,
  output logic                      overflow_o
);
  localparam int unsigned IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ACC_W  = WIDTH + GAIN_BITS + $clog2(CHANNELS) + 1;
  localparam int unsigned PROD_W = WIDTH + GAIN_BITS + 1;
  localparam logic [GAIN_BITS-1:0] UNITY = {1'b1, {(GAIN_BITS-1){1'b0}}};
  localparam logic [ACC_W-1:0] OUT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [ACC_W-1:0] OUT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'(4 * CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  // Signed sample times zero-extended gain, added to the running sum.
  function automatic logic signed [ACC_W-1:0] mac_fn(
    input logic signed [ACC_W-1:0] acc,
    input logic [WIDTH-1:0]        smp,
    input logic [GAIN_BITS-1:0]    gain
  );
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'($signed(smp)) * $signed(PROD_W'(gain));
    return acc + ACC_W'(prod);
  endfunction

  // Clamp a scaled sum to the output range; bit WIDTH flags that a clamp occurred.
  function automatic logic [WIDTH:0] sat_fn(input logic signed [ACC_W-1:0] v);
    logic [WIDTH:0] r;
    if (v > $signed(OUT_MAX)) begin
      r = {1'b1, OUT_MAX[WIDTH-1:0]};
    end else if (v < $signed(OUT_MIN)) begin
      r = {1'b1, OUT_MIN[WIDTH-1:0]};
    end else begin
      r = {1'b0, v[WIDTH-1:0]};
    end
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic                    lrck_q;
  logic                    armed_q, armed_d;
  logic [WIDTH-1:0]        snap_q [CHANNELS];
  logic [WIDTH-1:0]        snap_d [CHANNELS];
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_l_nx_s;
  logic [GAIN_BITS-1:0]    gain_l_q [CHANNELS];
  logic [GAIN_BITS-1:0]    gain_l_d [CHANNELS];
  logic                    mute_q, mute_d;
  logic [WIDTH-1:0]        left_q, left_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;
  logic                    rise_s, ovf_set_s, ovf_clr_s, clamp_s;
  logic [WIDTH:0]          sat_l_s;
  logic                    unused_msg_s;
`ifdef VOICE_MIXER_PAN_EN
  logic signed [ACC_W-1:0] acc_r_q, acc_r_d, acc_r_nx_s;
  logic [GAIN_BITS-1:0]    gain_r_q [CHANNELS];
  logic [GAIN_BITS-1:0]    gain_r_d [CHANNELS];
  logic [WIDTH-1:0]        right_q, right_d;
  logic [WIDTH:0]          sat_r_s;
`endif

  assign unused_msg_s = ^msg_i;

  // Next-state logic: register writes, frame sequencing, output staging, overflow.
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | ~lrck_i;
    snap_d     = snap_q;
    idx_d      = idx_q;
    acc_l_d    = acc_l_q;
    gain_l_d   = gain_l_q;
    mute_d     = mute_q;
    left_d     = left_q;
    valid_d    = 1'b0;
    ovf_set_s  = 1'b0;
    ovf_clr_s  = 1'b0;
    rise_s     = lrck_i & ~lrck_q & armed_q;
    acc_l_nx_s = mac_fn(acc_l_q, snap_q[idx_q], gain_l_q[idx_q]);
    sat_l_s    = sat_fn(acc_l_nx_s >>> (GAIN_BITS - 1));
    clamp_s    = sat_l_s[WIDTH];
`ifdef VOICE_MIXER_PAN_EN
    acc_r_d    = acc_r_q;
    gain_r_d   = gain_r_q;
    right_d    = right_q;
    acc_r_nx_s = mac_fn(acc_r_q, snap_q[idx_q], gain_r_q[idx_q]);
    sat_r_s    = sat_fn(acc_r_nx_s >>> (GAIN_BITS - 1));
    clamp_s    = sat_l_s[WIDTH] | sat_r_s[WIDTH];
`endif

    if (msg_en_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (msg_addr_i == BASE_ADDR + 32'(4 * i)) begin
          gain_l_d[i] = msg_i[GAIN_BITS-1:0];
`ifdef VOICE_MIXER_PAN_EN
          gain_r_d[i] = msg_i[16 +: GAIN_BITS];
`endif
        end else begin
          gain_l_d[i] = gain_l_q[i];
        end
      end
      if (msg_addr_i == CTRL_ADDR) begin
        mute_d    = msg_i[0];
        ovf_clr_s = msg_i[1];
      end else begin
        mute_d    = mute_q;
        ovf_clr_s = 1'b0;
      end
    end else begin
      ovf_clr_s = 1'b0;
    end

    // Results are registered as the last voice is accumulated, so they are
    // already visible (with valid) during the OUT cycle.
    case (state_q)
      S_IDLE: begin
        if (rise_s) begin
          for (int i = 0; i < CHANNELS; i++) begin
            snap_d[i] = samples_i[i*WIDTH +: WIDTH];
          end
          acc_l_d = '0;
`ifdef VOICE_MIXER_PAN_EN
          acc_r_d = '0;
`endif
          idx_d   = '0;
          state_d = S_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        ovf_set_s = rise_s;
        acc_l_d   = acc_l_nx_s;
`ifdef VOICE_MIXER_PAN_EN
        acc_r_d   = acc_r_nx_s;
`endif
        if (idx_q == LAST_IDX) begin
          state_d = S_OUT;
          valid_d = 1'b1;
          if (mute_q) begin
            left_d = '0;
`ifdef VOICE_MIXER_PAN_EN
            right_d = '0;
`endif
          end else begin
            left_d    = sat_l_s[WIDTH-1:0];
`ifdef VOICE_MIXER_PAN_EN
            right_d   = sat_r_s[WIDTH-1:0];
`endif
            ovf_set_s = rise_s | clamp_s;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_OUT: begin
        ovf_set_s = rise_s;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State register update with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      lrck_q     <= 1'b0;
      armed_q    <= 1'b0;
      idx_q      <= '0;
      acc_l_q    <= '0;
      mute_q     <= 1'b0;
      left_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        gain_l_q[i] <= UNITY;
        snap_q[i]   <= '0;
`ifdef VOICE_MIXER_PAN_EN
        gain_r_q[i] <= UNITY;
`endif
      end
`ifdef VOICE_MIXER_PAN_EN
      acc_r_q    <= '0;
      right_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lrck_q     <= lrck_i;
      armed_q    <= armed_d;
      idx_q      <= idx_d;
      acc_l_q    <= acc_l_d;
      mute_q     <= mute_d;
      left_q     <= left_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      gain_l_q   <= gain_l_d;
      snap_q     <= snap_d;
`ifdef VOICE_MIXER_PAN_EN
      gain_r_q   <= gain_r_d;
      acc_r_q    <= acc_r_d;
      right_q    <= right_d;
`endif
    end
  end

  assign left_o     = left_q;
`ifdef VOICE_MIXER_PAN_EN
  assign right_o    = right_q;
`else
  assign right_o    = left_q;
`endif
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed, table-driven bench for voice_mixer (CHANNELS=4, WIDTH=24, GAIN_BITS=8).
module tb_voice_mixer;
  localparam int          CH    = 4;
  localparam int          W     = 24;
  localparam logic [31:0] BASE  = 32'h3000_0100;
  localparam logic [31:0] CTRL  = 32'h3000_0110;
  localparam logic [7:0]  UNITY = 8'd128;
`ifdef VOICE_MIXER_PAN_EN
  localparam bit PAN_EN = 1'b1;
`else
  localparam bit PAN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          lrck;
  logic [CH*W-1:0] samples;
  logic          msg_en;
  logic [31:0]   msg_addr;
  logic [31:0]   msg;
  logic [W-1:0]  left;
  logic [W-1:0]  right;
  logic          valid;
  logic          overflow;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  voice_mixer #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .GAIN_BITS(8),
    .BASE_ADDR(BASE)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .lrck_i    (lrck),
    .samples_i (samples),
    .msg_en_i  (msg_en),
    .msg_addr_i(msg_addr),
    .msg_i     (msg),
    .left_o    (left),
    .right_o   (right),
    .valid_o   (valid),
    .overflow_o(overflow)
  );

  typedef struct packed {
    logic [CH-1:0][W-1:0] s;
    logic [7:0]           gl0;
    logic [7:0]           gr0;
    logic [W-1:0]         exp_l;
    logic [W-1:0]         exp_r;
    logic                 exp_ovf;
  } vec_t;

  function automatic vec_t mkv(input logic [W-1:0] s0, s1, s2, s3,
                               input logic [7:0] gl0, gr0,
                               input logic [W-1:0] el, er,
                               input logic eo);
    vec_t v;
    v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
    v.gl0 = gl0; v.gr0 = gr0;
    v.exp_l = el; v.exp_r = er; v.exp_ovf = eo;
    return v;
  endfunction

  function automatic logic [W-1:0] exp_right(input logic [W-1:0] el, er);
    return PAN_EN ? er : el;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    msg_en = 1'b1; msg_addr = a; msg = d;
    tick();
    msg_en = 1'b0; msg_addr = 32'd0; msg = 32'd0;
  endtask

  task automatic set_gain(input int i, input logic [7:0] gl, input logic [7:0] gr);
    write_reg(BASE + 32'(4 * i), {8'd0, gr, 8'd0, gl});
  endtask

  task automatic unity_all();
    for (int i = 0; i < CH; i++) set_gain(i, UNITY, UNITY);
  endtask

  task automatic fill(input logic [W-1:0] x);
    for (int i = 0; i < CH; i++) samples[i*W +: W] = x;
  endtask

  // Caller is in cycle T+start; returns k such that valid is seen in cycle T+k.
  task automatic wait_valid(input int start, output int lat);
    lat = -1;
    for (int k = start; k <= start + 20; k++) begin
      @(negedge clk);
      if (valid) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic do_frame(output int lat);
    lrck = 1'b0;
    tick();
    lrck = 1'b1;
    tick();
    wait_valid(1, lat);
    lrck = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [W-1:0] el, er, input logic eo);
    int lat;
    do_frame(lat);
    check({name, " latency"}, lat, 32'd5);
    check({name, " left"}, left, el);
    check({name, " right"}, right, er);
    check({name, " overflow"}, overflow, eo);
    tick();
    @(negedge clk);
    check({name, " valid pulse"}, valid, 32'd0);
    check({name, " left hold"}, left, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs [10];
    int   lat;
    int   nvalid;

    vecs[0] = mkv(24'd1000, 24'd1000, 24'd1000, 24'd1000, 8'd128, 8'd128, 24'd4000, 24'd4000, 1'b0);
    vecs[1] = mkv(24'h7FFFFF, 24'h7FFFFF, 24'd0, 24'd0, 8'd128, 8'd128, 24'h7FFFFF, 24'h7FFFFF, 1'b1);
    vecs[2] = mkv(-24'sd1000, 24'd0, 24'd0, 24'd0, 8'd64, 8'd0, -24'sd500, 24'd0, 1'b0);
    vecs[3] = mkv(-24'sd3, 24'd0, 24'd0, 24'd0, 8'd64, 8'd255, -24'sd2, -24'sd6, 1'b0);
    vecs[4] = mkv(24'h800000, 24'h800000, 24'h800000, 24'h800000, 8'd128, 8'd0, 24'h800000, 24'h800000, 1'b1);
    vecs[5] = mkv(24'd100, 24'd0, 24'd0, 24'd0, 8'd255, 8'd1, 24'd199, 24'd0, 1'b0);
    vecs[6] = mkv(24'h7FFFFF, 24'd0, 24'd0, 24'd0, 8'd128, 8'd0, 24'h7FFFFF, 24'd0, 1'b0);
    vecs[7] = mkv(24'd10, -24'sd20, 24'd30, -24'sd40, 8'd128, 8'd0, -24'sd20, -24'sd30, 1'b0);
    vecs[8] = mkv(24'd3, 24'd0, 24'd0, 24'd0, 8'd64, 8'd255, 24'd1, 24'd5, 1'b0);
    vecs[9] = mkv(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 8'd255, 8'd255, 24'h7FFFFF, 24'h7FFFFF, 1'b1);

    // Reset with lrck held high; release must not be taken as a rise.
    rst = 1'b1; lrck = 1'b1; msg_en = 1'b0; msg_addr = 32'd0; msg = 32'd0;
    fill(24'd1000);
    tick(); tick();
    @(negedge clk);
    check("reset left", left, 32'd0);
    check("reset right", right, 32'd0);
    check("reset valid", valid, 32'd0);
    check("reset overflow", overflow, 32'd0);
    rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      tick(); @(negedge clk);
      if (valid) nvalid++;
    end
    check("no rise at reset release", nvalid, 32'd0);
    check_frame("reset gains", 24'd4000, 24'd4000, 1'b0);

    // Table of single-frame mixes.
    for (int n = 0; n < 10; n++) begin
      set_gain(0, vecs[n].gl0, vecs[n].gr0);
      for (int i = 1; i < CH; i++) set_gain(i, UNITY, UNITY);
      write_reg(CTRL, 32'h2);
      samples = vecs[n].s;
      check_frame($sformatf("vec%0d", n), vecs[n].exp_l,
                  exp_right(vecs[n].exp_l, vecs[n].exp_r), vecs[n].exp_ovf);
    end

    // Overflow clear via control register.
    write_reg(CTRL, 32'h2);
    @(negedge clk);
    check("overflow clear", overflow, 32'd0);

    // Unmapped writes are ignored; gain writes mid-frame affect only later voices.
    unity_all();
    write_reg(32'h3000_0114, 32'h3);
    write_reg(32'h3000_0000, 32'h0);
    fill(24'd1000);
    lrck = 1'b0; tick();
    lrck = 1'b1; tick();
    msg_en = 1'b1; msg_addr = BASE + 32'd8; msg = 32'h0; tick();
    msg_addr = BASE; tick();
    msg_en = 1'b0; msg_addr = 32'd0;
    wait_valid(3, lat);
    lrck = 1'b0;
    check("acc write latency", lat, 32'd5);
    check("acc write left", left, 32'd3000);
    check("acc write right", right, 32'd3000);
    check("acc write overflow", overflow, 32'd0);
    check_frame("after acc write", 24'd2000, 24'd2000, 1'b0);

    // Second rise at T+2 is dropped and flags overflow.
    unity_all();
    write_reg(CTRL, 32'h2);
    fill(24'd1000);
    lrck = 1'b0; tick();
    lrck = 1'b1; tick();
    fill(24'd5); lrck = 1'b0; tick();
    lrck = 1'b1; tick();
    lrck = 1'b0;
    wait_valid(3, lat);
    check("double rise latency", lat, 32'd5);
    check("double rise left", left, 32'd4000);
    check("double rise right", right, 32'd4000);
    check("double rise overflow", overflow, 32'd1);
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      tick(); @(negedge clk);
      if (valid) nvalid++;
    end
    check("double rise no extra frame", nvalid, 32'd0);

    // Mute: valid still pulses, outputs zero, no clamp evaluation.
    write_reg(CTRL, 32'h3);
    fill(24'h7FFFFF);
    check_frame("mute", 24'd0, 24'd0, 1'b0);

    // Reset mid-frame discards the frame.
    write_reg(CTRL, 32'h0);
    fill(24'd0);
    samples[0 +: W] = 24'h7FFFFF;
    samples[W +: W] = 24'h7FFFFF;
    check_frame("pre-reset sat", 24'h7FFFFF, 24'h7FFFFF, 1'b1);
    lrck = 1'b0; tick();
    lrck = 1'b1; tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid reset left", left, 32'd0);
    check("mid reset right", right, 32'd0);
    check("mid reset valid", valid, 32'd0);
    check("mid reset overflow", overflow, 32'd0);
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      tick(); @(negedge clk);
      if (valid) nvalid++;
    end
    check("mid reset no valid", nvalid, 32'd0);
    lrck = 1'b0;
    fill(24'd1000);
    check_frame("post reset", 24'd4000, 24'd4000, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
